// File: rtl/dsa_pkg.sv
// Shared types and default sizes for the DSA image-memory path.
package dsa_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_HOST,
        OWN_CORE
    } mem_owner_t;

    localparam int DSA_ADDR_WIDTH = 18;
    localparam int DSA_DATA_WIDTH = 8;
    localparam int DSA_MEM_SIZE   = 262144;

endpackage

// File: rtl/dsa_sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module dsa_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/dsa_mem_arbiter.sv
// Single-port image RAM arbiter: host holding register, core req/gnt port,
// starvation guard, read-return tagging and access counters.
module dsa_mem_arbiter
    import dsa_pkg::*;
#(
    parameter int ADDR_WIDTH   = DSA_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DSA_DATA_WIDTH,
    parameter int MEM_SIZE     = DSA_MEM_SIZE,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_write_en,
    input  logic                  host_read_en,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    output logic [DATA_WIDTH-1:0] host_data_out,
    output logic                  host_rd_valid,
    input  logic                  core_busy,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  counters_clr,
    output logic [31:0]           reads_count,
    output logic [31:0]           writes_count,
    output logic                  host_overrun,
    output logic                  addr_err
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic                  host_pending;
    logic                  hold_we;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [SW-1:0]         starve_cnt;
    mem_owner_t            tag_owner;
    logic                  tag_oor;

    logic host_gnt, force_host, acc_we, acc_oor, any_gnt;
    logic host_pulse, host_accept, overrun_set;
    logic reads_inc, writes_inc;

    assign force_host = host_pending && starve_cnt == SW'(STARVE_LIMIT - 1);
    assign any_gnt    = host_gnt || core_gnt;

    // Grants are masked by reset so every output reads 0 while rst_n is low.
    always_comb begin
        host_gnt  = rst_n && host_pending && (force_host || !core_busy || !core_req);
        core_gnt  = rst_n && core_req && !host_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        acc_we    = 1'b0;
        if (host_gnt) begin
            mem_addr  = hold_addr;
            mem_wdata = hold_data;
            acc_we    = hold_we;
        end else if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            acc_we    = core_we;
        end
        acc_oor = any_gnt && !(64'(mem_addr) < 64'(MEM_SIZE));
        mem_en  = any_gnt && !acc_oor;
        mem_we  = mem_en && acc_we;
    end

    // A new pulse may replace the pending request only in the cycle it is granted.
    assign host_pulse  = host_write_en || host_read_en;
    assign host_accept = host_pulse && (!host_pending || host_gnt);
    assign overrun_set = (host_pulse && !host_accept) || (host_write_en && host_read_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_pending <= 1'b0;
            hold_we      <= 1'b0;
            hold_addr    <= '0;
            hold_data    <= '0;
            starve_cnt   <= '0;
        end else begin
            if (host_accept) begin
                host_pending <= 1'b1;
                hold_we      <= host_write_en;
                hold_addr    <= host_addr;
                hold_data    <= host_data_in;
            end else if (host_gnt) begin
                host_pending <= 1'b0;
            end
            if (host_gnt)
                starve_cnt <= '0;
            else if (host_pending)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_owner     <= OWN_NONE;
            tag_oor       <= 1'b0;
            host_data_out <= '0;
            host_rd_valid <= 1'b0;
            host_overrun  <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            if (host_gnt && !hold_we)
                tag_owner <= OWN_HOST;
            else if (core_gnt && !core_we)
                tag_owner <= OWN_CORE;
            else
                tag_owner <= OWN_NONE;
            tag_oor       <= acc_oor;
            host_rd_valid <= tag_owner == OWN_HOST;
            if (tag_owner == OWN_HOST)
                host_data_out <= tag_oor ? '0 : mem_rdata;
            if (counters_clr) begin
                host_overrun <= 1'b0;
                addr_err     <= 1'b0;
            end else begin
                if (overrun_set) host_overrun <= 1'b1;
                if (acc_oor)     addr_err     <= 1'b1;
            end
        end
    end

    assign core_rvalid = tag_owner == OWN_CORE;
    assign core_rdata  = (core_rvalid && !tag_oor) ? mem_rdata : '0;

    assign reads_inc  = any_gnt && !acc_we;
    assign writes_inc = any_gnt && acc_we;

    dsa_sat_counter #(.WIDTH(32)) u_reads (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (reads_inc),
        .clr   (counters_clr),
        .count (reads_count)
    );

    dsa_sat_counter #(.WIDTH(32)) u_writes (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (writes_inc),
        .clr   (counters_clr),
        .count (writes_count)
    );

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// Directed bench for dsa_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dsa_mem_arbiter;

    localparam int AW = 18;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_write_en, host_read_en;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data_in, host_data_out;
    logic          host_rd_valid;
    logic          core_busy, core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_gnt, core_rvalid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          counters_clr;
    logic [31:0]   reads_count, writes_count;
    logic          host_overrun, addr_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [0:262143];

    always #5 clk = ~clk;

    // MEM_SIZE one short of the address space so 0x3FFFF is out of range.
    dsa_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(262143), .STARVE_LIMIT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_write_en(host_write_en), .host_read_en(host_read_en),
        .host_addr(host_addr), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .host_rd_valid(host_rd_valid),
        .core_busy(core_busy), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .counters_clr(counters_clr),
        .reads_count(reads_count), .writes_count(writes_count),
        .host_overrun(host_overrun), .addr_err(addr_err)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = '0;
        rst_n = 1'b0; host_write_en = 0; host_read_en = 0; host_addr = '0;
        host_data_in = '0; core_busy = 0; core_req = 1; core_we = 0;
        core_addr = '0; core_wdata = '0; counters_clr = 0;

        // Reset state, even with core_req asserted
        #2;
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rd_valid", host_rd_valid, 0);
        chk("rst_reads", reads_count, 0);
        nxt(); core_req = 0;
        nxt(); rst_n = 1;

        // Host write 0x5A @0x10 then read it back, core idle
        nxt(); host_write_en = 1; host_addr = 18'h10; host_data_in = 8'h5A;
        #1 chk("w_not_yet", mem_en, 0);
        nxt(); host_write_en = 0;
        #1 chk("w_mem_we", mem_we, 1);
        chk("w_mem_addr", mem_addr, 18'h10);
        chk("w_mem_wdata", mem_wdata, 8'h5A);
        nxt(); host_read_en = 1;
        nxt(); host_read_en = 0;
        #1 chk("r_mem_en", mem_en, 1);
        chk("r_mem_we", mem_we, 0);
        nxt();
        #1 chk("r_valid_early", host_rd_valid, 0);
        nxt();
        #1 chk("r_valid", host_rd_valid, 1);
        chk("r_data", host_data_out, 8'h5A);
        chk("r_reads", reads_count, 1);
        chk("r_writes", writes_count, 1);
        nxt();
        #1 chk("r_valid_pulse", host_rd_valid, 0);

        // Starvation: host read waits while busy core holds the RAM
        nxt(); core_busy = 1; core_req = 1; core_addr = 18'h20;
        host_read_en = 1; host_addr = 18'h10;
        #1 chk("st_core_first", core_gnt, 1);
        for (int k = 1; k <= 64; k++) begin
            nxt(); host_read_en = 0;
            #1;
            if (k < 64) chk("st_core_gnt", core_gnt, 1);
            else begin
                chk("st_forced_core_gnt", core_gnt, 0);
                chk("st_forced_addr", mem_addr, 18'h10);
                chk("st_forced_en", mem_en, 1);
            end
        end
        nxt(); core_req = 0; core_busy = 0;
        nxt();
        #1 chk("st_rd_valid", host_rd_valid, 1);
        chk("st_rd_data", host_data_out, 8'h5A);
        chk("st_reads", reads_count, 66);

        // Overrun: second write pulse while first still pending
        nxt(); core_busy = 1; core_req = 1;
        host_write_en = 1; host_addr = 18'h30; host_data_in = 8'hA5;
        nxt(); host_addr = 18'h31; host_data_in = 8'h11;
        #1 chk("ov_not_yet", host_overrun, 0);
        nxt(); host_write_en = 0; core_req = 0;
        #1 chk("ov_set", host_overrun, 1);
        chk("ov_first_we", mem_we, 1);
        chk("ov_first_addr", mem_addr, 18'h30);
        chk("ov_first_data", mem_wdata, 8'hA5);
        nxt(); counters_clr = 1;
        #1 chk("ov_reads", reads_count, 68);
        chk("ov_writes", writes_count, 2);
        nxt(); counters_clr = 0;
        #1 chk("clr_overrun", host_overrun, 0);
        chk("clr_reads", reads_count, 0);
        chk("clr_writes", writes_count, 0);

        // Core in-range read then out-of-range read 0x3FFFF
        nxt(); core_req = 1; core_we = 0; core_addr = 18'h30;
        #1 chk("cr_mem_en", mem_en, 1);
        nxt(); core_addr = 18'h3FFFF;
        #1 chk("cr_rvalid", core_rvalid, 1);
        chk("cr_rdata", core_rdata, 8'hA5);
        chk("oor_gnt", core_gnt, 1);
        chk("oor_mem_en", mem_en, 0);
        nxt(); core_req = 0;
        #1 chk("oor_rvalid", core_rvalid, 1);
        chk("oor_rdata", core_rdata, 8'h00);
        chk("oor_addr_err", addr_err, 1);
        chk("oor_reads", reads_count, 2);

        // Saturation from a preloaded count, then clear against a grant
        nxt(); force dut.u_reads.count = 32'hFFFF_FFFE;
        core_req = 1; core_addr = 18'h30;
        #1 release dut.u_reads.count;
        chk("sat_preload", reads_count, 32'hFFFF_FFFE);
        nxt();
        #1 chk("sat_max", reads_count, 32'hFFFF_FFFF);
        nxt(); counters_clr = 1;
        #1 chk("sat_hold", reads_count, 32'hFFFF_FFFF);
        nxt(); counters_clr = 0; core_req = 0;
        #1 chk("sat_clr", reads_count, 0);
        chk("clr_addr_err", addr_err, 0);

        // Reset in the cycle after a core read grant, host request pending
        nxt(); core_busy = 1; core_req = 1; core_addr = 18'h30;
        host_read_en = 1; host_addr = 18'h10;
        nxt(); host_read_en = 0;
        #1 chk("mr_core_gnt", core_gnt, 1);
        nxt(); rst_n = 0; core_req = 0;
        #1 chk("mr_rvalid", core_rvalid, 0);
        chk("mr_rdata", core_rdata, 0);
        chk("mr_host_data", host_data_out, 0);
        chk("mr_mem_en", mem_en, 0);
        chk("mr_reads", reads_count, 0);
        chk("mr_rd_valid", host_rd_valid, 0);
        nxt(); rst_n = 1; core_busy = 0;
        #1 chk("mr_pending_clr", mem_en, 0);
        chk("mr_core_gnt_after", core_gnt, 0);
        nxt();
        #1 chk("mr_no_rd_valid", host_rd_valid, 0);
        chk("mr_no_rvalid", core_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
